fmul_seq_param: RTL and testbench

FMUL_SEQ_PARAM -- requirements
Module: fmul_seq_param

---
 rtl/fmul_seq_param_pkg.sv | 16 +
 rtl/fmul_seq_param_if.sv | 27 ++
 rtl/fmul_seq_param_mant_mul_iter.sv | 33 +++
 rtl/fmul_seq_param.sv | 94 +++++++++
 tb/tb_fmul_seq_param.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/fmul_seq_param_pkg.sv
// fmul_seq_param_pkg: shared state encoding, default widths and float helpers
package fmul_seq_param_pkg;
  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 10;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  function automatic int bias(int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  // exponent/mantissa bits of the quiet canonical NaN, sign excluded
  function automatic logic [63:0] nan_bits(int ew, int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction
endpackage

// File: rtl/fmul_seq_param_if.sv
// fmul_seq_param_if: operand/result handshake bundle of the sequential multiplier
interface fmul_seq_param_if #(
  parameter int EXP_W = fmul_seq_param_pkg::DEF_EXP_W,
  parameter int MAN_W = fmul_seq_param_pkg::DEF_MAN_W
);
  logic in_Valid, out_Ready;
  logic in_Sign_1, in_Sign_2;
  logic [EXP_W-1:0] in_Exponent_1, in_Exponent_2;
  logic [MAN_W-1:0] in_Mantissa_1, in_Mantissa_2;
  logic out_Valid, in_Ready;
  logic out_Sign;
  logic [EXP_W-1:0] out_Exponent;
  logic [MAN_W-1:0] out_Mantissa;
  logic SC_Exponent_Overflow, SC_Exponent_Underflow, SC_Invalid;
  modport slave (
    input in_Valid, in_Sign_1, in_Sign_2, in_Exponent_1, in_Exponent_2,
          in_Mantissa_1, in_Mantissa_2, in_Ready,
    output out_Ready, out_Valid, out_Sign, out_Exponent, out_Mantissa,
           SC_Exponent_Overflow, SC_Exponent_Underflow, SC_Invalid
  );
  modport master (
    output in_Valid, in_Sign_1, in_Sign_2, in_Exponent_1, in_Exponent_2,
           in_Mantissa_1, in_Mantissa_2, in_Ready,
    input out_Ready, out_Valid, out_Sign, out_Exponent, out_Mantissa,
          SC_Exponent_Overflow, SC_Exponent_Underflow, SC_Invalid
  );
endinterface

// File: rtl/fmul_seq_param_mant_mul_iter.sv
// mant_mul_iter: radix-2 shift-add multiplier, one multiplier bit per cycle
module mant_mul_iter #(
  parameter int W = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] mc;
  logic [CW-1:0] cnt;
  logic [W:0] sum;
  assign busy = cnt != '0;
  // low half holds the unconsumed multiplier bits, high half the partial sum
  assign sum = {1'b0, product[2*W-1:W]} + {1'b0, (product[0] ? mc : W'(0))};
  always_ff @(posedge clk)
    if (rst) begin
      mc <= '0;
      cnt <= '0;
      product <= '0;
    end else if (start) begin
      mc <= a;
      cnt <= CW'(W);
      product <= {{W{1'b0}}, b};
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      product <= {sum, product[W-1:1]};
    end
endmodule

// File: rtl/fmul_seq_param.sv
// fmul_seq_param: sequential floating-point multiplier with RNE rounding and flush-to-zero
module fmul_seq_param #(
  parameter int EXP_W = fmul_seq_param_pkg::DEF_EXP_W,
  parameter int MAN_W = fmul_seq_param_pkg::DEF_MAN_W
) (
  input logic in_Clock,
  input logic in_Reset,
  fmul_seq_param_if.slave bus
);
  import fmul_seq_param_pkg::*;
  localparam int EW2 = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam int CW = $clog2(MAN_W + 2);
  localparam int BIAS = bias(EXP_W);
  localparam int MAX_E = (1 << EXP_W) - 1;
  localparam logic [EXP_W+MAN_W-1:0] NAN = (EXP_W + MAN_W)'(nan_bits(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0] E_ONES = '1;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic s1, s2;
  logic [EXP_W-1:0] e1, e2;
  logic [MAN_W-1:0] m1, m2;
  logic start, mul_busy;
  logic [PW-1:0] prod;
  logic msb, guard, sticky, rnd, carry, sgn;
  logic [MAN_W-1:0] mant_n, mant_r;
  logic signed [EW2-1:0] exp_f;
  logic zero1, zero2, inf1, inf2, nan1, nan2, invalid, inf_any, zero_any, finite, ovf, unf;
  logic [EXP_W+MAN_W:0] res;
  assign start = state == S_IDLE && bus.in_Valid;
  assign bus.out_Ready = state == S_IDLE;
  assign bus.out_Valid = state == S_DONE;
  mant_mul_iter #(.W(MAN_W + 1)) u_mul (
    .clk(in_Clock),
    .rst(in_Reset),
    .start(start),
    .a({1'b1, bus.in_Mantissa_1}),
    .b({1'b1, bus.in_Mantissa_2}),
    .busy(mul_busy),
    .product(prod)
  );
  assign zero1 = e1 == '0;
  assign zero2 = e2 == '0;
  assign inf1 = e1 == E_ONES && m1 == '0;
  assign inf2 = e2 == E_ONES && m2 == '0;
  assign nan1 = e1 == E_ONES && m1 != '0;
  assign nan2 = e2 == E_ONES && m2 != '0;
  assign invalid = nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2);
  assign inf_any = inf1 || inf2;
  assign zero_any = zero1 || zero2;
  assign finite = !invalid && !inf_any && !zero_any;
  assign sgn = s1 ^ s2;
  always_comb begin
    msb = prod[PW-1];
    mant_n = msb ? prod[PW-2:MAN_W+1] : prod[PW-3:MAN_W];
    guard = msb ? prod[MAN_W] : prod[MAN_W-1];
    sticky = msb ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
    rnd = guard && (sticky || mant_n[0]);
    {carry, mant_r} = {1'b0, mant_n} + (MAN_W + 1)'(rnd);
    exp_f = EW2'(e1) + EW2'(e2) - EW2'(BIAS) + EW2'(msb) + EW2'(carry);
    ovf = exp_f >= EW2'(MAX_E);
    unf = exp_f <= EW2'(0);
    res = invalid ? {1'b0, NAN} :
          inf_any ? {sgn, E_ONES, {MAN_W{1'b0}}} :
          zero_any ? {sgn, {(EXP_W + MAN_W){1'b0}}} :
          ovf ? {sgn, E_ONES, {MAN_W{1'b0}}} :
          unf ? {sgn, {(EXP_W + MAN_W){1'b0}}} :
          {sgn, exp_f[EXP_W-1:0], mant_r};
  end
  always_ff @(posedge in_Clock)
    if (in_Reset) begin
      state <= S_IDLE;
      cnt <= '0;
      {s1, s2, e1, e2, m1, m2} <= '0;
      {bus.out_Sign, bus.out_Exponent, bus.out_Mantissa} <= '0;
      {bus.SC_Exponent_Overflow, bus.SC_Exponent_Underflow, bus.SC_Invalid} <= '0;
    end else if (start) begin
      {s1, e1, m1} <= {bus.in_Sign_1, bus.in_Exponent_1, bus.in_Mantissa_1};
      {s2, e2, m2} <= {bus.in_Sign_2, bus.in_Exponent_2, bus.in_Mantissa_2};
      cnt <= CW'(MAN_W + 1);
      state <= S_MUL;
    end else if (state == S_MUL && mul_busy) begin
      cnt <= cnt - CW'(1);
      state <= cnt == CW'(1) ? S_NORM : S_MUL;
    end else if (state == S_NORM) begin
      {bus.out_Sign, bus.out_Exponent, bus.out_Mantissa} <= res;
      bus.SC_Invalid <= invalid;
      bus.SC_Exponent_Overflow <= finite && ovf;
      bus.SC_Exponent_Underflow <= finite && !ovf && unf;
      state <= S_DONE;
    end else if (state == S_DONE && bus.in_Ready) begin
      state <= S_IDLE;
    end
endmodule

// File: tb/tb_fmul_seq_param.sv
// tb_fmul_seq_param: directed vectors and handshake/reset sequences for fmul_seq_param
module tb_fmul_seq_param;
  logic clk = 0;
  logic rst;
  int n_cmp = 0, n_bad = 0;
  fmul_seq_param_if bus ();
  fmul_seq_param dut (.in_Clock(clk), .in_Reset(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] a, b, y;
    logic [2:0] f;
  } vec_t;
  vec_t vecs [12];
  logic [15:0] y;
  logic [2:0] f;
  int lat;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic set_ops(input logic [15:0] a, input logic [15:0] b);
    {bus.in_Sign_1, bus.in_Exponent_1, bus.in_Mantissa_1} = a;
    {bus.in_Sign_2, bus.in_Exponent_2, bus.in_Mantissa_2} = b;
  endtask
  task automatic wait_done(inout int l);
    while (!bus.out_Valid && l < 50) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask
  task automatic release_result();
    bus.in_Ready = 1;
    @(posedge clk);
    #1;
    bus.in_Ready = 0;
  endtask
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r, output logic [2:0] fl, output int l);
    set_ops(a, b);
    bus.in_Valid = 1;
    @(posedge clk);
    #1;
    bus.in_Valid = 0;
    l = 0;
    wait_done(l);
    r = {bus.out_Sign, bus.out_Exponent, bus.out_Mantissa};
    fl = {bus.SC_Exponent_Overflow, bus.SC_Exponent_Underflow, bus.SC_Invalid};
    release_result();
  endtask
  initial begin
    vecs[0]  = '{16'h3E00, 16'h4000, 16'h4200, 3'b000};
    vecs[1]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 3'b100};
    vecs[2]  = '{16'h0400, 16'h0400, 16'h0000, 3'b010};
    vecs[3]  = '{16'h7C00, 16'h0000, 16'h7E00, 3'b001};
    vecs[4]  = '{16'hFC00, 16'h3C00, 16'hFC00, 3'b000};
    vecs[5]  = '{16'h8000, 16'h3C00, 16'h8000, 3'b000};
    vecs[6]  = '{16'h3C01, 16'h3C01, 16'h3C02, 3'b000};
    vecs[7]  = '{16'h3BFF, 16'h3C01, 16'h3C00, 3'b000};
    vecs[8]  = '{16'h3C00, 16'h3C00, 16'h3C00, 3'b000};
    vecs[9]  = '{16'hC000, 16'h4200, 16'hC600, 3'b000};
    vecs[10] = '{16'h7E00, 16'h3C00, 16'h7E00, 3'b001};
    vecs[11] = '{16'h3C00, 16'h7C00, 16'h7C00, 3'b000};
    rst = 1;
    bus.in_Valid = 0;
    bus.in_Ready = 0;
    set_ops(16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("reset out_Valid", 32'(bus.out_Valid), 32'd0);
    chk("reset out_Ready", 32'(bus.out_Ready), 32'd1);
    chk("reset result", 32'({bus.out_Sign, bus.out_Exponent, bus.out_Mantissa}), 32'h0);
    chk("reset flags", 32'({bus.SC_Exponent_Overflow, bus.SC_Exponent_Underflow, bus.SC_Invalid}), 32'h0);
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, y, f, lat);
      chk($sformatf("vec%0d result", i), 32'(y), 32'(vecs[i].y));
      chk($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].f));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd12);
    end
    // hold in DONE with in_Ready low, and a stray in_Valid pulse during MUL
    set_ops(16'h3E00, 16'h4000);
    bus.in_Valid = 1;
    @(posedge clk);
    #1;
    bus.in_Valid = 0;
    lat = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    set_ops(16'h7BFF, 16'h7BFF);
    bus.in_Valid = 1;
    @(posedge clk);
    #1;
    lat++;
    bus.in_Valid = 0;
    wait_done(lat);
    chk("hold latency", 32'(lat), 32'd12);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d result", k), 32'({bus.out_Sign, bus.out_Exponent, bus.out_Mantissa}), 32'h4200);
      chk($sformatf("hold%0d valid/ready", k), 32'({bus.out_Valid, bus.out_Ready}), 32'b10);
      chk($sformatf("hold%0d flags", k), 32'({bus.SC_Exponent_Overflow, bus.SC_Exponent_Underflow, bus.SC_Invalid}), 32'h0);
      @(posedge clk);
      #1;
    end
    release_result();
    chk("after release out_Ready", 32'({bus.out_Valid, bus.out_Ready}), 32'b01);
    // reset mid-MUL, with in_Valid also asserted to confirm reset wins
    set_ops(16'h7BFF, 16'h7BFF);
    bus.in_Valid = 1;
    @(posedge clk);
    #1;
    bus.in_Valid = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid-MUL busy", 32'(bus.out_Ready), 32'd0);
    rst = 1;
    bus.in_Valid = 1;
    @(posedge clk);
    #1;
    rst = 0;
    bus.in_Valid = 0;
    chk("abort out_Valid/out_Ready", 32'({bus.out_Valid, bus.out_Ready}), 32'b01);
    chk("abort result", 32'({bus.out_Sign, bus.out_Exponent, bus.out_Mantissa}), 32'h0);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    chk("abort no output", 32'({bus.out_Valid, bus.out_Ready}), 32'b01);
    do_op(16'h3C00, 16'h3C00, y, f, lat);
    chk("post-reset result", 32'(y), 32'h3C00);
    chk("post-reset flags", 32'(f), 32'h0);
    chk("post-reset latency", 32'(lat), 32'd12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
